mem_stage_lsu: RTL and testbench

MEM stage of the 5-stage RV32I core. It sits between the EX/MEM register and the MEM/WB register, and consumes the ex_mem_data_t produced by the execute stage. It runs loads and stores on a valid/ready data-memory port, handles byte/half/word alignment and sign extension, and stalls upstream stages while an access is outstanding. It owns the MEM/WB pipeline register and drives mem_wb_data_t to writeback.

---
 rtl/mem_stage_lsu_pkg.sv | 36 +++
 rtl/mem_stage_lsu_if.sv | 14 +
 rtl/mem_stage_lsu_align.sv | 25 ++
 rtl/mem_stage_lsu.sv | 83 ++++++++
 tb/tb_mem_stage_lsu.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared types and constants for the MEM-stage load/store unit
package mem_stage_lsu_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam logic [2:0] F3_LB = 3'b000;
    localparam logic [2:0] F3_LH = 3'b001;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT_R} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic [4:0] rd_addr;
        logic [DATA_WIDTH-1:0] rd_data2;
        logic [DATA_WIDTH-1:0] alu_result;
        logic RegWrite;
        logic MemWrite;
        logic MemRead;
        logic [1:0] WBSel;
    } ex_mem_data_t;
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic [4:0] rd_addr;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] mem_rdata;
        logic RegWrite;
        logic [1:0] WBSel;
    } mem_wb_data_t;
    // unknown funct3 encodings fall back to a word access
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        return (f3 == F3_LB || f3 == F3_LBU) ? SZ_B : (f3 == F3_LH || f3 == F3_LHU) ? SZ_H : SZ_W;
    endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: valid/ready data-memory port between the LSU and memory
interface mem_stage_lsu_if;
    import mem_stage_lsu_pkg::*;
    logic req;
    logic we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0] be;
    logic gnt;
    logic rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    modport master(output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// mem_stage_lsu_align: byte-lane steering for stores, load extraction/extension, misalignment detection
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  lsu_size_e             size_i,
    input  logic                  zext_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] rd_data2_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] load_o,
    output logic                  misaligned_o
);
    logic [DATA_WIDTH-1:0] lane;
    assign lane = rdata_i >> {addr_lo_i, 3'b000};
    // halfwords need even addresses, words need 4-byte alignment
    always_comb begin
        misaligned_o = (size_i == SZ_H && addr_lo_i[0]) || (size_i == SZ_W && addr_lo_i != 2'b00);
        be_o = size_i == SZ_B ? 4'b0001 << addr_lo_i : size_i == SZ_H ? 4'b0011 << {addr_lo_i[1], 1'b0} : 4'b1111;
        wdata_o = size_i == SZ_B ? {4{rd_data2_i[7:0]}} : size_i == SZ_H ? {2{rd_data2_i[15:0]}} : rd_data2_i;
        load_o = size_i == SZ_B ? {{(DATA_WIDTH-8){~zext_i & lane[7]}}, lane[7:0]} :
                 size_i == SZ_H ? {{(DATA_WIDTH-16){~zext_i & lane[15]}}, lane[15:0]} : rdata_i;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage, runs loads/stores on the data port, stalls upstream, owns the MEM/WB register
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid_i,
    input  ex_mem_data_t           ex_data_i,
    output logic                   mem_stall_o,
    mem_stage_lsu_if.master        dmem,
    output logic                   misaligned_o,
    output logic                   wb_valid_o,
    output mem_wb_data_t           wb_data_o
);
    lsu_state_e state_q, state_d;
    logic wb_valid_q;
    mem_wb_data_t wb_q, wb_d;
    logic mem_op, is_load, mis, req, complete;
    logic [3:0] be;
    logic [DATA_WIDTH-1:0] wdata, load_data;

    mem_stage_lsu_align u_align (
        .size_i(f3_size(ex_data_i.instruction[14:12])),
        .zext_i(ex_data_i.instruction[14]),
        .addr_lo_i(ex_data_i.alu_result[1:0]),
        .rd_data2_i(ex_data_i.rd_data2),
        .rdata_i(dmem.rdata),
        .be_o(be),
        .wdata_o(wdata),
        .load_o(load_data),
        .misaligned_o(mis)
    );

    // the EX/MEM register is frozen while stalled, so gating by req keeps the port stable through REQ
    assign dmem.req = req;
    assign dmem.we = req & ~is_load;
    assign dmem.addr = req ? {ex_data_i.alu_result[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem.wdata = req ? wdata : '0;
    assign dmem.be = req ? be : 4'b0000;
    assign wb_valid_o = wb_valid_q;
    assign wb_data_o = wb_q;

    // request/completion/next-state logic; a misaligned op completes in IDLE without touching memory
    always_comb begin
        mem_op = ex_valid_i & (ex_data_i.MemRead | ex_data_i.MemWrite);
        is_load = ex_data_i.MemRead;
        req = state_q == LSU_REQ || (state_q == LSU_IDLE && mem_op && !mis);
        complete = state_q == LSU_WAIT_R ? dmem.rvalid :
                   state_q == LSU_REQ ? dmem.gnt & ~is_load : mis | (dmem.gnt & ~is_load);
        mem_stall_o = mem_op & ~complete;
        misaligned_o = state_q == LSU_IDLE && mem_op && mis;
        state_d = state_q == LSU_WAIT_R ? (dmem.rvalid ? LSU_IDLE : LSU_WAIT_R) :
                  !req ? LSU_IDLE :
                  !dmem.gnt ? LSU_REQ :
                  is_load ? LSU_WAIT_R : LSU_IDLE;
    end

    // next MEM/WB contents; a dropped misaligned op retires with its register write suppressed
    always_comb begin
        wb_d.instruction = ex_data_i.instruction;
        wb_d.pc_plus4 = ex_data_i.pc_plus4;
        wb_d.rd_addr = ex_data_i.rd_addr;
        wb_d.alu_result = ex_data_i.alu_result;
        wb_d.WBSel = ex_data_i.WBSel;
        wb_d.RegWrite = ex_valid_i & ex_data_i.RegWrite & ~(mem_op & mis);
        wb_d.mem_rdata = (mem_op && is_load && !mis) ? load_data : '0;
    end

    // FSM state and MEM/WB register; the register advances on the edge the stall drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            wb_valid_q <= 1'b0;
            wb_q <= '0;
        end else begin
            state_q <= state_d;
            if (!mem_stall_o) begin
                wb_valid_q <= ex_valid_i;
                wb_q <= wb_d;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven, hand-sequenced and randomized checks of the MEM-stage LSU
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic ex_valid;
    ex_mem_data_t ex;
    logic stall, mis_o, wbv;
    mem_wb_data_t wbd;
    int checks = 0;
    int errors = 0;
    logic exp_wbv;
    mem_wb_data_t exp_wb;

    always #5 clk = ~clk;

    mem_stage_lsu_if dmem();

    mem_stage_lsu dut (
        .clk(clk),
        .rst(rst),
        .ex_valid_i(ex_valid),
        .ex_data_i(ex),
        .mem_stall_o(stall),
        .dmem(dmem),
        .misaligned_o(mis_o),
        .wb_valid_o(wbv),
        .wb_data_o(wbd)
    );

    typedef struct {
        logic v, rd, wr, rw;
        logic [2:0] f3;
        logic [31:0] addr, rd2, rdata;
        int gd, rv;
        logic [3:0] be;
        logic [31:0] wdata, ld;
        logic mis;
        int stalls;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int v, rd, wr, rw, f3, input logic [31:0] addr, rd2, rdata,
                                input int gd, rv, be, input logic [31:0] wdata, ld, input int mis, stalls);
        vec_t t;
        t.v = 1'(v); t.rd = 1'(rd); t.wr = 1'(wr); t.rw = 1'(rw); t.f3 = 3'(f3);
        t.addr = addr; t.rd2 = rd2; t.rdata = rdata; t.gd = gd; t.rv = rv;
        t.be = 4'(be); t.wdata = wdata; t.ld = ld; t.mis = 1'(mis); t.stalls = stalls;
        return t;
    endfunction

    // reference: sizes in bytes, lanes by offset arithmetic, sign by two's-complement wrap
    function automatic vec_t model(input vec_t t);
        int size, off;
        longint val, m;
        bit load, store;
        size = (t.f3 == 3'd0 || t.f3 == 3'd4) ? 1 : (t.f3 == 3'd1 || t.f3 == 3'd5) ? 2 : 4;
        off = int'(t.addr[1:0]);
        load = t.v && t.rd;
        store = t.v && t.wr && !t.rd;
        t.mis = (load || store) && (off % size != 0);
        t.be = size == 4 ? 4'hF : 4'(((1 << size) - 1) << off);
        t.wdata = size == 1 ? (t.rd2 & 32'hFF) * 32'h01010101 : size == 2 ? (t.rd2 & 32'hFFFF) * 32'h00010001 : t.rd2;
        m = longint'(1) << (8 * size);
        val = (longint'(t.rdata) >> (8 * off)) % m;
        if (t.f3 < 3'd4 && size < 4 && val >= m / 2) val -= m;
        t.ld = (load && !t.mis) ? 32'(val) : 32'h0;
        t.stalls = t.mis ? 0 : load ? t.gd + t.rv : store ? t.gd : 0;
        return t;
    endfunction

    function automatic mem_wb_data_t wb_model(input ex_mem_data_t e, input logic v, input logic mis, input logic [31:0] ld);
        mem_wb_data_t w;
        w.instruction = e.instruction;
        w.pc_plus4 = e.pc_plus4;
        w.rd_addr = e.rd_addr;
        w.alu_result = e.alu_result;
        w.mem_rdata = ld;
        w.RegWrite = v & e.RegWrite & ~mis;
        w.WBSel = e.WBSel;
        return w;
    endfunction

    task automatic run(input vec_t t);
        logic [31:0] instr;
        logic aligned_op;
        instr = $urandom;
        instr[14:12] = t.f3;
        ex_valid = t.v;
        ex.instruction = instr;
        ex.pc_plus4 = $urandom;
        ex.rd_addr = 5'($urandom);
        ex.rd_data2 = t.rd2;
        ex.alu_result = t.addr;
        ex.RegWrite = t.rw;
        ex.MemWrite = t.wr;
        ex.MemRead = t.rd;
        ex.WBSel = 2'($urandom);
        aligned_op = t.v && (t.rd || t.wr) && !t.mis;
        for (int c = 0; c <= t.stalls; c++) begin
            dmem.gnt = (c == t.gd);
            dmem.rvalid = (c == t.gd + t.rv) ? 1'b1 : (c <= t.gd ? 1'($urandom) : 1'b0);
            dmem.rdata = (c == t.gd + t.rv) ? t.rdata : $urandom;
            @(negedge clk);
            chk("stall", 256'(stall), 256'(c < t.stalls));
            chk("req", 256'(dmem.req), 256'(aligned_op && c <= t.gd));
            chk("misaligned", 256'(mis_o), 256'(c == 0 && t.mis));
            if (aligned_op && c <= t.gd) begin
                chk("addr", 256'(dmem.addr), 256'(t.addr & ~32'h3));
                chk("we", 256'(dmem.we), 256'(t.wr && !t.rd));
                chk("be", 256'(dmem.be), 256'(t.be));
                chk("wdata", 256'(dmem.wdata), 256'(t.wdata));
            end
            if (c < t.stalls) begin
                chk("wb_hold_valid", 256'(wbv), 256'(exp_wbv));
                chk("wb_hold_data", 256'(wbd), 256'(exp_wb));
            end
            @(posedge clk);
            #1;
        end
        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b0;
        exp_wbv = t.v;
        exp_wb = wb_model(ex, t.v, t.mis, t.ld);
        chk("wb_valid", 256'(wbv), 256'(exp_wbv));
        chk("wb_mem_rdata", 256'(wbd.mem_rdata), 256'(t.ld));
        chk("wb_data", 256'(wbd), 256'(exp_wb));
    endtask

    vec_t tbl[13];
    vec_t t;

    initial begin
        //            v rd wr rw f3 addr          rd2           rdata         gd rv be    wdata         ld            mis stalls
        tbl[0]  = mk(1, 0, 1, 0, 2, 32'h100,      32'hDEADBEEF, 32'h0,        0, 1, 'hF, 32'hDEADBEEF, 32'h0,        0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0, 32'h103,      32'h000000A5, 32'h0,        0, 1, 'h8, 32'hA5A5A5A5, 32'h0,        0, 0);
        tbl[2]  = mk(1, 1, 0, 1, 0, 32'h102,      32'h0,        32'h12F03456, 0, 1, 'h4, 32'h0,        32'hFFFFFFF0, 0, 1);
        tbl[3]  = mk(1, 1, 0, 1, 4, 32'h102,      32'h0,        32'h12F03456, 0, 1, 'h4, 32'h0,        32'h000000F0, 0, 1);
        tbl[4]  = mk(1, 1, 0, 1, 2, 32'h100,      32'h0,        32'hCAFEF00D, 3, 2, 'hF, 32'h0,        32'hCAFEF00D, 0, 5);
        tbl[5]  = mk(1, 1, 0, 1, 1, 32'h101,      32'h0,        32'h11223344, 0, 1, 'h0, 32'h0,        32'h0,        1, 0);
        tbl[6]  = mk(1, 0, 1, 0, 1, 32'h102,      32'h1234BEEF, 32'h0,        2, 1, 'hC, 32'hBEEFBEEF, 32'h0,        0, 2);
        tbl[7]  = mk(1, 1, 0, 1, 1, 32'h102,      32'h0,        32'h80017FFF, 0, 1, 'hC, 32'h0,        32'hFFFF8001, 0, 1);
        tbl[8]  = mk(1, 1, 0, 1, 5, 32'h102,      32'h0,        32'h80017FFF, 1, 1, 'hC, 32'h0,        32'h00008001, 0, 2);
        tbl[9]  = mk(1, 0, 0, 1, 2, 32'h104,      32'h55555555, 32'h0,        0, 1, 'h0, 32'h0,        32'h0,        0, 0);
        tbl[10] = mk(0, 1, 0, 1, 2, 32'h100,      32'h0,        32'h77777777, 0, 1, 'h0, 32'h0,        32'h0,        0, 0);
        tbl[11] = mk(1, 0, 1, 0, 2, 32'h102,      32'h13572468, 32'h0,        0, 1, 'h0, 32'h0,        32'h0,        1, 0);
        tbl[12] = mk(1, 1, 1, 1, 2, 32'h108,      32'h11111111, 32'h55AA55AA, 0, 1, 'hF, 32'h11111111, 32'h55AA55AA, 0, 1);

        rst = 1'b1;
        ex_valid = 1'b0;
        ex = '0;
        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_wb_valid", 256'(wbv), 256'(0));
        chk("reset_wb_data", 256'(wbd), 256'(0));
        chk("reset_misaligned", 256'(mis_o), 256'(0));
        chk("reset_req", 256'(dmem.req), 256'(0));
        chk("reset_stall", 256'(stall), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_wbv = 1'b0;
        exp_wb = '0;

        for (int i = 0; i < 13; i++) run(tbl[i]);

        // reset while waiting for load data; the late rvalid must be discarded
        ex_valid = 1'b1;
        ex.MemRead = 1'b1;
        ex.MemWrite = 1'b0;
        ex.RegWrite = 1'b1;
        ex.instruction[14:12] = 3'b010;
        ex.alu_result = 32'h200;
        dmem.gnt = 1'b1;
        @(negedge clk);
        chk("rstseq_req", 256'(dmem.req), 256'(1));
        chk("rstseq_stall0", 256'(stall), 256'(1));
        @(posedge clk);
        #1;
        dmem.gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstseq_wait_req", 256'(dmem.req), 256'(0));
        chk("rstseq_wait_stall", 256'(stall), 256'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_valid = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata = 32'h12345678;
        @(negedge clk);
        chk("rstseq_stall", 256'(stall), 256'(0));
        chk("rstseq_req_after", 256'(dmem.req), 256'(0));
        chk("rstseq_wb_valid", 256'(wbv), 256'(0));
        chk("rstseq_wb_cleared", 256'(wbd), 256'(0));
        @(posedge clk);
        #1;
        dmem.rvalid = 1'b0;
        chk("rstseq_wb_valid2", 256'(wbv), 256'(0));
        chk("rstseq_wb_rdata", 256'(wbd.mem_rdata), 256'(0));
        chk("rstseq_wb_regwrite", 256'(wbd.RegWrite), 256'(0));
        exp_wbv = 1'b0;
        exp_wb = wb_model(ex, 1'b0, 1'b0, 32'h0);
        run(model(mk(1, 1, 0, 1, 2, 32'h300, 32'h0, 32'h0BADF00D, 0, 1, 0, 32'h0, 32'h0, 0, 0)));

        for (int i = 0; i < 300; i++) begin
            t.v = ($urandom % 8) != 0;
            t.rd = 1'($urandom);
            t.wr = 1'($urandom);
            t.rw = 1'($urandom);
            t.f3 = 3'($urandom);
            t.addr = $urandom;
            t.rd2 = $urandom;
            t.rdata = $urandom;
            t.gd = int'($urandom_range(0, 3));
            t.rv = int'($urandom_range(1, 3));
            run(model(t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
